voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice scheduler placed between the key/note event source and a bank of NUM_VOICES single-note synth datapaths, each with its own ADSR envelope and wave generator. It accepts note-on and note-off events over a valid/ready handshake and assigns each note-on to a free voice slot, or to the oldest slot when all are busy. For each voice it drives the note_in-style trigger pulse, a sustained gate, and the latched note/octave that the per-voice datapath consumes.

## Interface
- NUM_VOICES, 4, number of voice slots; range 2..16.
- AGE_W, 8, width of the per-slot age counter; the counter saturates.
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- ev_valid  in  1  event present
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  4  note index 0..11
- ev_octave  in  3  octave 0..6
- voice_trig  out  NUM_VOICES  one-cycle load pulse per voice; drives the voice datapath's note_in
- voice_gate  out  NUM_VOICES  1 while the voice is held
- voice_note  out  4*NUM_VOICES  latched note; slot i occupies bits [4i+3:4i]
- voice_octave  out  3*NUM_VOICES  latched octave; slot i occupies bits [3i+2:3i]
- active_count  out  $clog2(NUM_VOICES+1)  number of voices with gate=1
- drop  out  1  one-cycle pulse when a note-on is discarded

## Operation
- FSM states: IDLE, SCAN, COMMIT. Reset enters IDLE.
- ev_ready is 1 only in IDLE with reset high.
- An event is accepted when ev_valid && ev_ready. ev_on, ev_note and ev_octave are captured into registers on that edge.
- **SCAN** visits slot index 0..NUM_VOICES-1, one slot per cycle, and records:
  - match: lowest-index slot with gate=1 and the same note and octave.
  - free: lowest-index slot with gate=0.
  - oldest: slot with gate=1 and the largest age; ties go to the lowest index.
- **COMMIT**, note-on:
  - If a match exists, retrigger that slot: pulse trig, set age to 0.
  - Otherwise, if a free slot exists, load the note and octave into it, set gate=1, pulse trig, set age to 0.
  - Otherwise, apply the full-bank behaviour selected under Configuration.
- **COMMIT**, note-off:
  - If a match exists, clear its gate. Note, octave and age are held so the release phase keeps its pitch.
  - If no match exists, do nothing and do not pulse drop.
- Age update: on every COMMIT that assigns or retriggers a slot, every other slot with gate=1 increments its age, saturating at 2^AGE_W-1. Ages are frozen at all other times.
- active_count is registered and updated in COMMIT.
- Reset values: all outputs 0 except ev_ready; all ages 0; ev_ready=0 while reset is low.
- Reset asserted in SCAN or COMMIT abandons the event. All slots clear and no trig pulse is emitted.

## Timing
- Accept edge = cycle 0. SCAN covers cycles 1..NUM_VOICES. COMMIT is cycle NUM_VOICES+1.
- voice_trig, voice_gate, voice_note, voice_octave, active_count and drop become visible at cycle NUM_VOICES+2. The trig and drop pulses last exactly one cycle.
- ev_ready returns to 1 at cycle NUM_VOICES+2. Maximum throughput is one event per NUM_VOICES+2 cycles.
- Holding ev_valid while ev_ready=0 is legal. The event is taken on the next IDLE cycle.
- For a given slot, voice_trig and the new voice_note/voice_octave become valid on the same edge. The voice datapath samples them on its following cycle.

## Configuration
- VOICE_STEAL_EN defined: a note-on with every slot gated steals the oldest slot. That slot gets the new note and octave, trig pulses, age is set to 0, and the others age as above. drop stays 0.
- VOICE_STEAL_EN undefined: a note-on with every slot gated is discarded. drop pulses at cycle NUM_VOICES+2, and all slot state, including ages, is unchanged.

## Structure
- Package synth_voice_pkg holds:
  - the FSM state enum;
  - NOTE_W=4, OCT_W=3 and default AGE_W;
  - the event struct {on, note, octave}.
- Sub-module voice_slot, instantiated NUM_VOICES times:
  - holds gate, note, octave and age registers;
  - takes load, retrigger, release and age_inc strobes;
  - produces the trig pulse.
- The allocator top holds the FSM, the scan index, the match/free/oldest trackers and the active counter.

## Test plan
- NUM_VOICES=4, after reset: note-on (note 9, octave 4) -> slot 0 trig at cycle 6, voice_note[3:0]=9, voice_octave[2:0]=4, gate=0001, active_count=1.
- Note-ons 0, 2, 4 (octave 4), then note-off note 2 -> gate=0101. A following note-on for note 7 lands in slot 1 (lowest free).
- Repeat note-on for a note already held in slot 2 -> slot 2 retriggers, gate unchanged, active_count unchanged, no new slot used.
- Five distinct note-ons, with VOICE_STEAL_EN -> fifth note replaces slot 0 (oldest), drop=0. Without VOICE_STEAL_EN -> drop pulses once and slots are unchanged.
- Note-off for a note not held -> no output change, drop=0, ev_ready high again at cycle 6.
- Reset pulled low during SCAN with ev_valid held high -> all outputs 0 next cycle, ev_ready=0 until reset releases, no trig pulse.

Source files
------------

// File: rtl/synth_voice_pkg.sv
// Shared types and widths for the polyphonic voice allocator and its slots.
package synth_voice_pkg;

  localparam int NOTE_W        = 4;
  localparam int OCT_W         = 3;
  localparam int AGE_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
  } note_event_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: held gate, latched pitch, saturating age and the trig pulse
// that loads the downstream voice datapath.
module voice_slot
  import synth_voice_pkg::*;
#(
  parameter int AGE_W = AGE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              retrig,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] note_d,
  input  logic [OCT_W-1:0]  octave_d,
  output logic              trig,
  output logic              gate,
  output logic [NOTE_W-1:0] note,
  output logic [OCT_W-1:0]  octave,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      trig   <= 1'b0;
      gate   <= 1'b0;
      note   <= '0;
      octave <= '0;
      age    <= '0;
    end else begin
      trig <= load | retrig;
      if (load) begin
        gate   <= 1'b1;
        note   <= note_d;
        octave <= octave_d;
        age    <= '0;
      end else if (retrig) begin
        age <= '0;
      end else begin
        // Release keeps pitch and age so the envelope tail stays in tune.
        if (rel) gate <= 1'b0;
        if (age_inc && gate && (age != '1)) age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: serial scan of the slots, then one commit cycle.
// Define VOICE_STEAL_EN to steal the oldest voice when the bank is full.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = AGE_W_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ev_valid,
  output logic                              ev_ready,
  input  logic                              ev_on,
  input  logic [NOTE_W-1:0]                 ev_note,
  input  logic [OCT_W-1:0]                  ev_octave,
  output logic [NUM_VOICES-1:0]             voice_trig,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [NOTE_W*NUM_VOICES-1:0]      voice_note,
  output logic [OCT_W*NUM_VOICES-1:0]       voice_octave,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
  output logic                              drop
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t      state, state_nxt;
  note_event_t       ev_q;
  logic              accept;
  logic [IDX_W-1:0]  scan_idx;

  logic              scan_gate;
  logic [NOTE_W-1:0] scan_note;
  logic [OCT_W-1:0]  scan_oct;
  logic [AGE_W-1:0]  scan_age;

  logic              match_found, free_found, old_found;
  logic [IDX_W-1:0]  match_idx, free_idx;
  logic [AGE_W-1:0]  old_age;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]  old_idx;
`endif

  logic [NUM_VOICES-1:0] load_v, retrig_v, rel_v;
  logic                  age_inc, drop_d, cnt_up, cnt_dn;
  logic [AGE_W-1:0]      age_s [NUM_VOICES];

  assign ev_ready = reset && (state == IDLE);
  assign accept   = ev_valid && ev_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign scan_gate = voice_gate[scan_idx];
  assign scan_note = voice_note[scan_idx*NOTE_W +: NOTE_W];
  assign scan_oct  = voice_octave[scan_idx*OCT_W +: OCT_W];
  assign scan_age  = age_s[scan_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ev_q        <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_found   <= 1'b0;
      old_age     <= '0;
`ifdef VOICE_STEAL_EN
      old_idx     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ev_q.on     <= ev_on;
            ev_q.note   <= ev_note;
            ev_q.octave <= ev_octave;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (scan_gate && !match_found &&
              (scan_note == ev_q.note) && (scan_oct == ev_q.octave)) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!scan_gate && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (scan_gate && (!old_found || (scan_age > old_age))) begin
            old_found <= 1'b1;
            old_age   <= scan_age;
`ifdef VOICE_STEAL_EN
            old_idx   <= scan_idx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_v   = '0;
    retrig_v = '0;
    rel_v    = '0;
    age_inc  = 1'b0;
    drop_d   = 1'b0;
    cnt_up   = 1'b0;
    cnt_dn   = 1'b0;
    if (state == COMMIT) begin
      if (ev_q.on) begin
        if (match_found) begin
          retrig_v[match_idx] = 1'b1;
          age_inc             = 1'b1;
        end else if (free_found) begin
          load_v[free_idx] = 1'b1;
          age_inc          = 1'b1;
          cnt_up           = 1'b1;
        end else if (old_found) begin
`ifdef VOICE_STEAL_EN
          load_v[old_idx] = 1'b1;
          age_inc         = 1'b1;
`else
          drop_d = 1'b1;
`endif
        end
      end else if (match_found) begin
        rel_v[match_idx] = 1'b1;
        cnt_dn           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_count <= '0;
      drop         <= 1'b0;
    end else begin
      drop <= drop_d;
      if (cnt_up)      active_count <= active_count + 1'b1;
      else if (cnt_dn) active_count <= active_count - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (load_v[i]),
      .retrig   (retrig_v[i]),
      .rel      (rel_v[i]),
      .age_inc  (age_inc),
      .note_d   (ev_q.note),
      .octave_d (ev_q.octave),
      .trig     (voice_trig[i]),
      .gate     (voice_gate[i]),
      .note     (voice_note[i*NOTE_W +: NOTE_W]),
      .octave   (voice_octave[i*OCT_W +: OCT_W]),
      .age      (age_s[i])
    );
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator with a slot-array reference model.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int AGE_MAX = 255;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_on = 1'b0;
  logic [3:0]      ev_note = '0;
  logic [2:0]      ev_octave = '0;
  logic [NV-1:0]   voice_trig, voice_gate;
  logic [4*NV-1:0] voice_note;
  logic [3*NV-1:0] voice_octave;
  logic [2:0]      active_count;
  logic            drop;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .ev_octave    (ev_octave),
    .voice_trig   (voice_trig),
    .voice_gate   (voice_gate),
    .voice_note   (voice_note),
    .voice_octave (voice_octave),
    .active_count (active_count),
    .drop         (drop)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: one entry per voice slot.
  logic       m_gate [NV];
  logic [3:0] m_note [NV];
  logic [2:0] m_oct  [NV];
  int         m_age  [NV];
  logic [NV-1:0] exp_trig;
  logic          exp_drop;

  logic [NV-1:0]   obs_trig, obs_gate, obs_trig2;
  logic [4*NV-1:0] obs_note;
  logic [3*NV-1:0] obs_oct;
  logic [2:0]      obs_count;
  logic            obs_drop, obs_drop2, obs_ready, obs_early;

  function automatic logic [NV-1:0] m_gate_vec();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_gate[i];
    return v;
  endfunction

  function automatic logic [4*NV-1:0] m_note_vec();
    logic [4*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i*4 +: 4] = m_note[i];
    return v;
  endfunction

  function automatic logic [3*NV-1:0] m_oct_vec();
    logic [3*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i*3 +: 3] = m_oct[i];
    return v;
  endfunction

  function automatic logic [2:0] m_count();
    int c = 0;
    for (int i = 0; i < NV; i++) c += int'(m_gate[i]);
    return 3'(c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0; m_note[i] = '0; m_oct[i] = '0; m_age[i] = 0;
    end
    exp_trig = '0;
    exp_drop = 1'b0;
  endtask

  task automatic model_apply(input logic on, input logic [3:0] n, input logic [2:0] o);
    int match = -1, free = -1, oldest = -1, target = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i] && m_note[i] == n && m_oct[i] == o && match < 0) match = i;
      if (!m_gate[i] && free < 0) free = i;
      if (m_gate[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
    end
    exp_trig = '0;
    exp_drop = 1'b0;
    if (on) begin
      if (match >= 0) target = match;
      else if (free >= 0) target = free;
`ifdef VOICE_STEAL_EN
      else target = oldest;
`else
      else exp_drop = 1'b1;
`endif
      if (target >= 0) begin
        for (int j = 0; j < NV; j++)
          if (j != target && m_gate[j] && m_age[j] < AGE_MAX) m_age[j]++;
        m_age[target]  = 0;
        m_gate[target] = 1'b1;
        m_note[target] = n;
        m_oct[target]  = o;
        exp_trig[target] = 1'b1;
      end
    end else if (match >= 0) begin
      m_gate[match] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ev_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    model_reset();
  endtask

  // Drives one event, updates the model, and captures what the DUT shows at
  // cycle NUM_VOICES+2 and the cycle after.
  task automatic run_event(input logic on, input logic [3:0] n, input logic [2:0] o);
    int waited = 0;
    obs_early = 1'b0;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = on; ev_note = n; ev_octave = o;
    while (!ev_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ev_ready) begin
      n_total++;
      $display("FAIL accept_timeout: ev_ready=%0b after %0d cycles, required 1", ev_ready, waited);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
    model_apply(on, n, o);
    for (int k = 1; k <= NV; k++) begin
      @(posedge clk);
      #1 if (voice_trig != '0 || drop || ev_ready) obs_early = 1'b1;
    end
    @(posedge clk);
    #1;
    obs_trig = voice_trig; obs_gate = voice_gate; obs_note = voice_note;
    obs_oct = voice_octave; obs_count = active_count; obs_drop = drop;
    obs_ready = ev_ready;
    @(posedge clk);
    #1;
    obs_trig2 = voice_trig; obs_drop2 = drop;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (ev_ready !== 1'b0) $display("FAIL reset_ready_low: got %0b want 0", ev_ready);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (ev_ready !== 1'b1) $display("FAIL reset_ready_high: got %0b want 1", ev_ready);
    else n_pass++;
    n_total++;
    if ({voice_trig, voice_gate, voice_note, voice_octave, active_count, drop} !== '0)
      $display("FAIL reset_outputs: trig=%b gate=%b note=%h oct=%h cnt=%0d drop=%b want all 0",
               voice_trig, voice_gate, voice_note, voice_octave, active_count, drop);
    else n_pass++;
  endtask

  task automatic test_first_note();
    do_reset();
    run_event(1'b1, 4'd9, 3'd4);
    n_total++;
    if (obs_trig !== 4'b0001) $display("FAIL first_trig: got %b want 0001", obs_trig);
    else n_pass++;
    n_total++;
    if (obs_note[3:0] !== 4'd9 || obs_oct[2:0] !== 3'd4)
      $display("FAIL first_pitch: got note %0d oct %0d want 9/4", obs_note[3:0], obs_oct[2:0]);
    else n_pass++;
    n_total++;
    if (obs_gate !== 4'b0001 || obs_count !== 3'd1)
      $display("FAIL first_gate_count: got gate %b cnt %0d want 0001/1", obs_gate, obs_count);
    else n_pass++;
    n_total++;
    if (obs_early !== 1'b0 || obs_ready !== 1'b1)
      $display("FAIL first_timing: early=%b ready=%b want 0/1", obs_early, obs_ready);
    else n_pass++;
    n_total++;
    if (obs_trig2 !== 4'b0000) $display("FAIL first_trig_width: got %b want 0000", obs_trig2);
    else n_pass++;
  endtask

  task automatic test_lowest_free();
    do_reset();
    run_event(1'b1, 4'd0, 3'd4);
    run_event(1'b1, 4'd2, 3'd4);
    run_event(1'b1, 4'd4, 3'd4);
    run_event(1'b0, 4'd2, 3'd4);
    n_total++;
    if (obs_gate !== 4'b0101 || obs_count !== 3'd2 || obs_trig !== 4'b0000)
      $display("FAIL release_gate: got gate %b cnt %0d trig %b want 0101/2/0000", obs_gate, obs_count, obs_trig);
    else n_pass++;
    n_total++;
    if (obs_note[7:4] !== 4'd2) $display("FAIL release_holds_pitch: got %0d want 2", obs_note[7:4]);
    else n_pass++;
    run_event(1'b1, 4'd7, 3'd4);
    n_total++;
    if (obs_trig !== 4'b0010 || obs_gate !== 4'b0111 || obs_note[7:4] !== 4'd7)
      $display("FAIL lowest_free: got trig %b gate %b note1 %0d want 0010/0111/7", obs_trig, obs_gate, obs_note[7:4]);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    run_event(1'b1, 4'd4, 3'd4);
    n_total++;
    if (obs_trig !== 4'b0100 || obs_gate !== 4'b0111 || obs_count !== 3'd3)
      $display("FAIL retrigger: got trig %b gate %b cnt %0d want 0100/0111/3", obs_trig, obs_gate, obs_count);
    else n_pass++;
  endtask

  task automatic test_off_unheld();
    run_event(1'b0, 4'd9, 3'd0);
    n_total++;
    if (obs_trig !== 4'b0000 || obs_gate !== 4'b0111 || obs_drop !== 1'b0 || obs_note !== m_note_vec())
      $display("FAIL off_unheld: got trig %b gate %b drop %b note %h want 0000/0111/0/%h",
               obs_trig, obs_gate, obs_drop, obs_note, m_note_vec());
    else n_pass++;
    n_total++;
    if (obs_ready !== 1'b1 || obs_early !== 1'b0)
      $display("FAIL off_unheld_ready: ready=%b early=%b want 1/0", obs_ready, obs_early);
    else n_pass++;
  endtask

  task automatic test_full_bank();
    logic [3:0] notes [5];
    notes[0] = 4'd1; notes[1] = 4'd3; notes[2] = 4'd5; notes[3] = 4'd8; notes[4] = 4'd10;
    do_reset();
    for (int i = 0; i < 4; i++) run_event(1'b1, notes[i], 3'd2);
    run_event(1'b1, notes[4], 3'd5);
`ifdef VOICE_STEAL_EN
    n_total++;
    if (obs_trig !== 4'b0001 || obs_drop !== 1'b0 || obs_note[3:0] !== 4'd10 || obs_oct[2:0] !== 3'd5)
      $display("FAIL steal_oldest: got trig %b drop %b note0 %0d oct0 %0d want 0001/0/10/5",
               obs_trig, obs_drop, obs_note[3:0], obs_oct[2:0]);
    else n_pass++;
`else
    n_total++;
    if (obs_trig !== 4'b0000 || obs_drop !== 1'b1 || obs_note[3:0] !== 4'd1 || obs_oct[2:0] !== 3'd2)
      $display("FAIL full_drop: got trig %b drop %b note0 %0d oct0 %0d want 0000/1/1/2",
               obs_trig, obs_drop, obs_note[3:0], obs_oct[2:0]);
    else n_pass++;
`endif
    n_total++;
    if (obs_gate !== 4'b1111 || obs_count !== 3'd4 || obs_drop2 !== 1'b0 || obs_trig2 !== 4'b0000)
      $display("FAIL full_after: got gate %b cnt %0d drop2 %b trig2 %b want 1111/4/0/0000",
               obs_gate, obs_count, obs_drop2, obs_trig2);
    else n_pass++;
    // A second full-bank note-on exercises age ordering after the first outcome.
    run_event(1'b1, 4'd11, 3'd6);
    n_total++;
    if (obs_trig !== exp_trig || obs_drop !== exp_drop || obs_note !== m_note_vec())
      $display("FAIL full_second: got trig %b drop %b note %h want %b/%b/%h",
               obs_trig, obs_drop, obs_note, exp_trig, exp_drop, m_note_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    run_event(1'b1, 4'd3, 3'd2);
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 4'd5; ev_octave = 3'd3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({voice_trig, voice_gate, voice_note, voice_octave, active_count, drop, ev_ready} !== '0)
      $display("FAIL midscan_clear: trig=%b gate=%b note=%h oct=%h cnt=%0d drop=%b ready=%b want all 0",
               voice_trig, voice_gate, voice_note, voice_octave, active_count, drop, ev_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (ev_ready !== 1'b0 || voice_trig !== '0)
      $display("FAIL midscan_hold: ready=%b trig=%b want 0/0000", ev_ready, voice_trig);
    else n_pass++;
    @(negedge clk) reset = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (ev_ready !== 1'b1) $display("FAIL midscan_release: ready=%b want 1", ev_ready);
    else n_pass++;
    // The held event is taken on the first IDLE edge after release.
    @(posedge clk);
    #1 ev_valid = 1'b0;
    model_apply(1'b1, 4'd5, 3'd3);
    repeat (NV + 1) @(posedge clk);
    #1;
    n_total++;
    if (voice_trig !== exp_trig || voice_gate !== m_gate_vec() || voice_note !== m_note_vec())
      $display("FAIL midscan_pending: trig=%b gate=%b note=%h want %b/%b/%h",
               voice_trig, voice_gate, voice_note, exp_trig, m_gate_vec(), m_note_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int e = 0; e < 60; e++) begin
      logic on;
      logic [3:0] n;
      logic [2:0] o;
      on = ($urandom_range(0, 2) != 0);
      n  = 4'($urandom_range(0, 3));
      o  = 3'($urandom_range(0, 1));
      run_event(on, n, o);
      n_total++;
      if (obs_trig !== exp_trig || obs_drop !== exp_drop)
        $display("FAIL rand_pulse[%0d]: got trig %b drop %b want %b/%b", e, obs_trig, obs_drop, exp_trig, exp_drop);
      else n_pass++;
      n_total++;
      if (obs_gate !== m_gate_vec() || obs_count !== m_count())
        $display("FAIL rand_gate[%0d]: got gate %b cnt %0d want %b/%0d", e, obs_gate, obs_count, m_gate_vec(), m_count());
      else n_pass++;
      n_total++;
      if (obs_note !== m_note_vec() || obs_oct !== m_oct_vec())
        $display("FAIL rand_pitch[%0d]: got note %h oct %h want %h/%h", e, obs_note, obs_oct, m_note_vec(), m_oct_vec());
      else n_pass++;
      n_total++;
      if (obs_early !== 1'b0 || obs_ready !== 1'b1 || obs_trig2 !== '0 || obs_drop2 !== 1'b0)
        $display("FAIL rand_timing[%0d]: early %b ready %b trig2 %b drop2 %b want 0/1/0/0",
                 e, obs_early, obs_ready, obs_trig2, obs_drop2);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_lowest_free();
    test_retrigger();
    test_off_unheld();
    test_full_bank();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
